// File: rtl/wb_trace_buffer.sv
// Commit-trace recorder: snoops the writeback register-file write port and queues
// {seq, pc, addr, data} entries in a first-word-fall-through FIFO for a debug reader.
module wb_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CNTW  = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_en,
  input  logic                       i_clr,
  input  logic                       i_reg_write,
  input  logic [4:0]                 i_write_addr,
  input  logic [31:0]                i_data,
  input  logic [31:0]                i_pc,
  output logic                       o_rd_valid,
  input  logic                       i_rd_ready,
  output logic [CNTW-1:0]            o_rd_seq,
  output logic [31:0]                o_rd_pc,
  output logic [4:0]                 o_rd_addr,
  output logic [31:0]                o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow,
  output logic [CNTW-1:0]            o_drop_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [CNTW-1:0] seq;
    logic [31:0]     pc;
    logic [4:0]      addr;
    logic [31:0]     data;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic [CNTW-1:0] r_seq;
  logic            r_overflow;
  logic [CNTW-1:0] r_drop_cnt;

  logic   w_commit, w_full, w_valid, w_pop, w_push, w_drop;
  entry_t w_head;

  assign w_commit = i_en & i_reg_write & (i_write_addr != 5'd0);
  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_valid  = (r_count != '0);
  assign w_pop    = w_valid & i_rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push   = w_commit & (~w_full | w_pop);
  assign w_drop   = w_commit & w_full & ~w_pop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (i_clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_seq      <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_commit) r_seq <= r_seq + 1'b1;
      if (w_push)   r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
    end
  end

  // Storage is not reset; the read side is masked while empty instead.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_clr) r_mem[r_wr_ptr] <= '{seq: r_seq, pc: i_pc, addr: i_write_addr, data: i_data};
  end

  assign w_head     = w_valid ? r_mem[r_rd_ptr] : '0;
  assign o_rd_valid = w_valid;
  assign o_rd_seq   = w_head.seq;
  assign o_rd_pc    = w_head.pc;
  assign o_rd_addr  = w_head.addr;
  assign o_rd_data  = w_head.data;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_drop_cnt = r_drop_cnt;
endmodule

// File: doc/wb_trace_buffer.md
# wb_trace_buffer

Hardware commit-trace recorder for the 5-stage MIPS processor. Sits beside the writeback stage, snoops the register-file write port (RegWrite, WriteAddr, Data) plus the PC of the committing instruction, and queues one entry per architectural register write in a FIFO. A debug reader drains the FIFO through a valid/ready handshake, so traces can be checked by hardware without a testbench printing debug outputs cycle by cycle. Each entry carries a sequence tag, so dropped entries are detectable.

## Interface
- DEPTH, 16: FIFO entries; power of two, 2..256.
- CNTW, 16: width of sequence tag and drop counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- En  in  1  capture enable; 0 = ignore the write port.
- Clr  in  1  synchronous clear of FIFO, overflow flag, drop counter and sequence counter.
- In_RegWrite  in  1  writeback-stage register write strobe.
- In_WriteAddr  in  5  destination register.
- In_Data  in  32  write data.
- In_PC  in  32  PC of the committing instruction.
- Rd_Valid  out  1  head entry available.
- Rd_Ready  in  1  reader accepts head entry.
- Rd_Seq  out  CNTW  head sequence tag.
- Rd_PC  out  32  head PC.
- Rd_Addr  out  5  head destination register.
- Rd_Data  out  32  head write data.
- Count  out  log2(DEPTH)+1  occupied entries.
- Overflow  out  1  sticky; set when an entry is dropped.
- DropCnt  out  CNTW  saturating count of dropped entries.

## Operation
- Commit event: En & In_RegWrite & (In_WriteAddr != 0), sampled at the rising edge. Writes to $0 are never recorded and never consume a sequence number.
- Each commit event takes the current sequence counter value as its tag. The counter then increments, wrapping modulo 2^CNTW, whether or not the entry is stored.
- Push: the entry {Seq, PC, Addr, Data} is written at the tail when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- Drop: a commit event while full with no pop in the same cycle. The entry is discarded, Overflow is set to 1, and DropCnt increments, saturating at 2^CNTW-1.
- Pop: Rd_Valid & Rd_Ready at the edge removes the head.
- Rd_Ready while empty has no effect.
- Output style: first-word-fall-through. Rd_* show the head entry whenever Rd_Valid=1, and are don't-care when Rd_Valid=0.
- Rd_Valid = (Count != 0).
- Push and pop in the same cycle:
  - Count is unchanged.
  - Legal at every occupancy, including 0, where pop is suppressed because Rd_Valid=0 and push proceeds.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decided by Count, not by pointer equality.
- Clr has priority over push and pop in the same cycle. The event is discarded, and sequence counter, Count, Overflow and DropCnt all become 0.
- En=0 has no effect on the read side; draining continues.

## Timing
- Reset (Rst_n=0, asynchronous):
  - Count=0, Rd_Valid=0, Overflow=0, DropCnt=0, sequence counter=0.
  - Rd_Seq, Rd_PC, Rd_Addr and Rd_Data read 0. Storage is not required to clear; the outputs are masked to 0 while empty.
- Reset mid-operation discards all entries immediately. No partial pop or push is retained.
- Capture latency: a commit sampled at edge N gives Rd_Valid=1 and valid Rd_* after edge N when the FIFO was empty.
- Pop latency: after a pop at edge N, the next entry (or Rd_Valid=0) appears after edge N.
- Sustained throughput: 1 push plus 1 pop per cycle.
- All outputs change only on Clk edges or asynchronous reset; there are no combinational input-to-output paths.

## Test plan
- Reset/idle:
  - Stimulus: hold Rst_n=0, then release with no commits.
  - Required: Count=0, Rd_Valid=0, Overflow=0, DropCnt=0.
  - Stimulus: In_RegWrite=1 with In_WriteAddr=0, In_Data=32'hDEAD.
  - Required: Count stays 0; the first real commit carries Seq=0.
- Single commit:
  - Stimulus: En=1, commit PC=32'h0000_0010, Addr=8, Data=32'd42.
  - Required: Rd_Valid=1 after 1 edge with Rd_Seq=0, Rd_PC=16, Rd_Addr=8, Rd_Data=42. After a pop, Rd_Valid=0.
- Fill and drop:
  - Stimulus: DEPTH=16, Rd_Ready=0, 18 commits.
  - Required: Count=16, Overflow=1, DropCnt=2.
  - Stimulus: drain.
  - Required: Seq 0..15 in order. The next commit gets Seq=18.
- Simultaneous push/pop at full:
  - Stimulus: full FIFO, one commit with Rd_Ready=1.
  - Required: Count stays 16, DropCnt unchanged, the new entry lands at the tail.
  - Stimulus: same with Rd_Ready=0.
  - Required: DropCnt increments.
- Streaming wrap:
  - Stimulus: Rd_Ready=1 held, 40 back-to-back commits with Data=i.
  - Required: Count never exceeds 1, Rd_Data sequence 0..39, no drops (pointer wrap exercised).
- Clear and async reset mid-stream:
  - Stimulus: Clr asserted together with a commit at Count=5.
  - Required: everything is 0 next cycle and the commit is not recorded.
  - Stimulus: Rst_n pulsed low between edges with Count=3.
  - Required: Rd_Valid drops to 0 immediately.
